// File: rtl/miso_multipath_combiner.sv
// ============================================================================
// Module   : miso_multipath_combiner
// Brief    : Two-path delay/gain combiner with rounded, saturated 8-bit output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module miso_multipath_combiner #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int MAX_DELAY = 15,
    parameter int DLY_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pathone,
    input  logic [DATA_W-1:0] pathtwo,
    input  logic [COEF_W-1:0] gain_one,
    input  logic [COEF_W-1:0] gain_two,
    input  logic [DLY_W-1:0]  delay_one,
    input  logic [DLY_W-1:0]  delay_two,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 2;

    localparam logic [DLY_W-1:0]        c_max_dly = DLY_W'(MAX_DELAY);
    localparam logic signed [SUM_W-1:0] c_round   = SUM_W'(2 ** (COEF_W - 2));
    localparam logic signed [SUM_W-1:0] c_out_max = SUM_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] c_out_min = SUM_W'(-(2 ** (DATA_W - 1)));

    // Entry 0 is the sample accepted one valid cycle ago.
    logic signed [DATA_W-1:0] r_hist1 [MAX_DELAY];
    logic signed [DATA_W-1:0] r_hist2 [MAX_DELAY];

    logic [DLY_W-1:0]         w_sel1;
    logic [DLY_W-1:0]         w_sel2;
    logic signed [DATA_W-1:0] w_tap1;
    logic signed [DATA_W-1:0] w_tap2;
    logic signed [PROD_W-1:0] w_p1;
    logic signed [PROD_W-1:0] w_p2;
    logic signed [PROD_W-1:0] r_p1;
    logic signed [PROD_W-1:0] r_p2;
    logic                     r_v1;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_scaled;
    logic [DATA_W-1:0]        r_out;
    logic                     r_sat;
    logic                     r_out_valid;

    always_comb begin
        w_sel1 = delay_one;
        w_sel2 = delay_two;
        if (delay_one > c_max_dly) w_sel1 = c_max_dly;
        if (delay_two > c_max_dly) w_sel2 = c_max_dly;
        w_tap1 = $signed(pathone);
        w_tap2 = $signed(pathtwo);
        if (w_sel1 != '0) w_tap1 = r_hist1[w_sel1 - DLY_W'(1)];
        if (w_sel2 != '0) w_tap2 = r_hist2[w_sel2 - DLY_W'(1)];
    end

    // Operands are widened first so the product keeps its full precision.
    assign w_p1 = PROD_W'(w_tap1) * PROD_W'($signed(gain_one));
    assign w_p2 = PROD_W'(w_tap2) * PROD_W'($signed(gain_two));

    assign w_sum    = SUM_W'(r_p1) + SUM_W'(r_p2) + c_round;
    assign w_scaled = w_sum >>> (COEF_W - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                r_hist1[i] <= '0;
                r_hist2[i] <= '0;
            end
        end else if (in_valid) begin
            r_hist1[0] <= $signed(pathone);
            r_hist2[0] <= $signed(pathtwo);
            for (int i = 1; i < MAX_DELAY; i++) begin
                r_hist1[i] <= r_hist1[i-1];
                r_hist2[i] <= r_hist2[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_p1 <= '0;
            r_p2 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_p1 <= w_p1;
                r_p2 <= w_p2;
            end
        end
    end

    // Output sample and clip flag hold across invalid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                if (w_scaled > c_out_max) begin
                    r_out <= c_out_max[DATA_W-1:0];
                    r_sat <= 1'b1;
                end else if (w_scaled < c_out_min) begin
                    r_out <= c_out_min[DATA_W-1:0];
                    r_sat <= 1'b1;
                end else begin
                    r_out <= w_scaled[DATA_W-1:0];
                    r_sat <= 1'b0;
                end
            end
        end
    end

    assign out       = r_out;
    assign sat       = r_sat;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_miso_multipath_combiner.sv
// ============================================================================
// Module   : tb_miso_multipath_combiner
// Brief    : Directed-vector bench for miso_multipath_combiner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miso_multipath_combiner;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] pathone;
    logic [7:0] pathtwo;
    logic [7:0] gain_one;
    logic [7:0] gain_two;
    logic [3:0] delay_one;
    logic [3:0] delay_two;
    logic [7:0] out;
    logic       out_valid;
    logic       sat;

    int nvec  = 0;
    int nfail = 0;

    // Expected results for the two samples in flight; index 1 is due now.
    logic       pv [2];
    logic [7:0] po [2];
    logic       ps [2];
    logic [7:0] last_o;
    logic       last_s;

    miso_multipath_combiner #(
        .DATA_W   (8),
        .COEF_W   (8),
        .MAX_DELAY(15),
        .DLY_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .pathone  (pathone),
        .pathtwo  (pathtwo),
        .gain_one (gain_one),
        .gain_two (gain_two),
        .delay_one(delay_one),
        .delay_two(delay_two),
        .out      (out),
        .out_valid(out_valid),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            po[i] = 8'h00;
            ps[i] = 1'b0;
        end
        last_o = 8'h00;
        last_s = 1'b0;
    endtask

    // One cycle: check the sample issued two cycles ago, then drive this one.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ga, input logic [7:0] gb,
                        input logic [3:0] da, input logic [3:0] db,
                        input logic [7:0] eo, input logic es);
        @(negedge clk);
        if (pv[1]) begin
            last_o = po[1];
            last_s = ps[1];
        end
        nvec++;
        assert (out_valid === pv[1]) else begin
            nfail++;
            $error("FAIL out_valid: got %0b expected %0b", out_valid, pv[1]);
        end
        nvec++;
        assert ({out, sat} === {last_o, last_s}) else begin
            nfail++;
            $error("FAIL out/sat: got %0d/%0b expected %0d/%0b",
                   $signed(out), sat, $signed(last_o), last_s);
        end
        pv[1] = pv[0]; po[1] = po[0]; ps[1] = ps[0];
        pv[0] = v;     po[0] = eo;    ps[0] = es;
        in_valid  = v;
        pathone   = a;
        pathtwo   = b;
        gain_one  = ga;
        gain_two  = gb;
        delay_one = da;
        delay_two = db;
    endtask

    task automatic idle();
        step(1'b0, 8'h11, 8'h22, 8'h7F, 8'h7F, 4'd2, 4'd5, 8'h00, 1'b0);
    endtask

    // Asynchronous reset pulse a few ns after a rising edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        nvec++;
        assert ({out, out_valid, sat} === 10'b0) else begin
            nfail++;
            $error("FAIL async_reset: got out=%0d v=%0b sat=%0b expected 0/0/0",
                   $signed(out), out_valid, sat);
        end
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        pathone = '0; pathtwo = '0; gain_one = '0; gain_two = '0;
        delay_one = '0; delay_two = '0;
        clear_model();
        repeat (2) @(negedge clk);
        nvec++;
        assert ({out, out_valid, sat} === 10'b0) else begin
            nfail++;
            $error("FAIL reset_state: got out=%0d v=%0b sat=%0b expected 0/0/0",
                   $signed(out), out_valid, sat);
        end
        rst = 1'b0;

        // Averaging mode
        step(1'b1, 8'h7F, 8'h7F, 8'h40, 8'h40, 4'd0, 4'd0, 8'd127, 1'b0);
        step(1'b1, 8'h55, 8'h55, 8'h40, 8'h40, 4'd0, 4'd0, 8'd85,  1'b0);
        step(1'b1, 8'h63, 8'h63, 8'h40, 8'h40, 4'd0, 4'd0, 8'd99,  1'b0);
        // Saturation both ways
        step(1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'd0, 4'd0, 8'h7F,  1'b1);
        step(1'b1, 8'h80, 8'h80, 8'h7F, 8'h7F, 4'd0, 4'd0, 8'h80,  1'b1);
        // Opposite-sign gains, then floor rounding of a negative sum
        step(1'b1, 8'd100, 8'd20, 8'h40, 8'hC0, 4'd0, 4'd0, 8'd40, 1'b0);
        step(1'b1, 8'hFD, 8'h00, 8'h40, 8'h40, 4'd0, 4'd0, 8'hFF,  1'b0);
        idle();
        idle();

        // Mid-stream reset with two samples in flight
        step(1'b1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 4'd0, 4'd0, 8'h7F, 1'b1);
        step(1'b1, 8'h30, 8'h30, 8'h40, 8'h40, 4'd0, 4'd0, 8'h30, 1'b0);
        async_reset();
        // Delay 1 after reset reads a zero history, then the prior sample
        step(1'b1, 8'd100, 8'd100, 8'h40, 8'h40, 4'd1, 4'd1, 8'd0,   1'b0);
        step(1'b1, 8'd0,   8'd0,   8'h40, 8'h40, 4'd1, 4'd1, 8'd100, 1'b0);
        idle();
        idle();

        // Delay of 3 on path two, gapless
        async_reset();
        step(1'b1, 8'd0, 8'd100, 8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd50, 1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        idle();
        idle();

        // Same run with gaps: no shift while idle, output holds over the gap
        async_reset();
        step(1'b1, 8'd0, 8'd100, 8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        repeat (4) idle();
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd50, 1'b0);
        repeat (4) idle();
        step(1'b1, 8'd0, 8'd0,   8'h40, 8'h40, 4'd0, 4'd3, 8'd0,  1'b0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/miso_multipath_combiner.md
Name: miso_multipath_combiner

Overview:
- Two-input, one-output multipath combiner for the voice-channel datapath.
- Each signed 8-bit sample stream passes through a programmable per-path delay line and a signed gain.
- The weighted paths are summed with rounding and saturation, giving one signed 8-bit output stream.
- Sits between the per-path channel/receive blocks and the downstream audio sink.

Parameters:
- DATA_W, 8: sample width (signed two's complement) for pathone, pathtwo and out.
- COEF_W, 8: gain width, signed Q1.7 (8'sh40 = 0.5, 8'sh7F ≈ 0.992).
- MAX_DELAY, 15: maximum per-path delay in valid samples.
- DLY_W, 4: delay-select width, equal to clog2(MAX_DELAY+1).

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies pathone/pathtwo/gains/delays for this cycle.
- pathone  in  DATA_W  signed sample, path 1.
- pathtwo  in  DATA_W  signed sample, path 2.
- gain_one  in  COEF_W  signed Q1.7 gain, path 1.
- gain_two  in  COEF_W  signed Q1.7 gain, path 2.
- delay_one  in  DLY_W  path-1 delay in samples.
- delay_two  in  DLY_W  path-2 delay in samples.
- out  out  DATA_W  signed combined sample, registered.
- out_valid  out  1  out carries a new sample.
- sat  out  1  the current out sample was clipped.

Behaviour:
Clocking and reset:
- Clock is clk; reset is rst, asynchronous and active-high.
- While rst is high: out=0, out_valid=0, sat=0, all delay-line entries=0, pipeline registers=0.
- Reset asserted mid-stream discards all in-flight samples.
- The first in_valid after rst deasserts sees an all-zero history.

Delay lines:
- Each path keeps a history of the last MAX_DELAY accepted samples.
- History shifts only on cycles with in_valid=1; when in_valid=0 all state holds and out_valid=0 on the corresponding output cycle.
- Tap selection: delay d=0 selects the current input sample; d=k selects the sample accepted k valid cycles earlier.
- A delay value greater than MAX_DELAY is clamped to MAX_DELAY.
- Delay and gain inputs are sampled together with the data on each in_valid. A change applies from that sample on, with no glitch handling beyond that.

Arithmetic, per accepted sample:
- p1 = tap1 × gain_one and p2 = tap2 × gain_two, each a signed 16-bit product.
- s = p1 + p2 (signed 17-bit) + 64 rounding term, then arithmetic shift right by 7 (floor).
- If s > 127: out=127 and sat=1. If s < −128: out=−128 and sat=1. Otherwise out=s and sat=0.
- With both gains at 8'sh40, equal inputs x on both paths yield exactly x for all x in [−128,127]. This is the averaging mode.

Pipeline and latency:
- Stage 1 registers p1 and p2; stage 2 registers out and sat.
- out_valid is in_valid delayed by exactly 2 cycles. Sustained in_valid gives one output per cycle.
- out and sat hold their last values while out_valid=0.

Test Plan:
- Reset: assert rst asynchronously mid-stream -> out=0, out_valid=0, sat=0 immediately. The first post-reset sample with delay 1 sees a zero history.
- Averaging: gains 8'sh40, delays 0, pathone=pathtwo=8'sh7F, then 8'sh55, then 8'sh63 on consecutive valid cycles -> out=127, 85, 99 with out_valid 2 cycles after each input, sat=0.
- Positive saturation: gains 8'sh7F, both inputs 127 -> s=252 -> out=127, sat=1.
- Negative saturation: gains 8'sh7F, both inputs −128 -> s=−254 -> out=−128, sat=1.
- Delay: gains 8'sh40, delay_one=0, delay_two=3, pathone=0. Drive pathtwo=100 on valid sample 0, then zeros -> out=0 for samples 0–2, out=50 on output sample 3, then 0.
- Valid gating: in_valid low for 4 cycles between samples -> no history shift, out_valid low over the gap. Delay-line output sequence identical to a gapless run.
